// File: rtl/vx_warp_sched.sv
// Warp scheduler: per-warp active/stall/PC/tmask state plus a registered issue stage
// that hands up to SCHEDULE_WIDTH eligible warps per cycle to fetch in round-robin order.
module vx_warp_sched #(
    parameter int NUM_WARPS      = 4,
    parameter int SCHEDULE_WIDTH = 1,
    parameter int NUM_THREADS    = 4,
    parameter int XLEN           = 32,
    parameter int UUID_WIDTH     = 44,
    localparam int NW_WIDTH      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               spawn_valid,
    input  logic [NW_WIDTH-1:0]                spawn_wid,
    input  logic [NUM_THREADS-1:0]             spawn_tmask,
    input  logic [XLEN-1:0]                    spawn_pc,
    input  logic                               unlock_valid,
    input  logic [NW_WIDTH-1:0]                unlock_wid,
    input  logic                               done_valid,
    input  logic [NW_WIDTH-1:0]                done_wid,
    output logic [SCHEDULE_WIDTH-1:0]          sched_valid,
    output logic [SCHEDULE_WIDTH*UUID_WIDTH-1:0]  sched_uuid,
    output logic [SCHEDULE_WIDTH*NW_WIDTH-1:0]    sched_wid,
    output logic [SCHEDULE_WIDTH*NUM_THREADS-1:0] sched_tmask,
    output logic [SCHEDULE_WIDTH*XLEN-1:0]        sched_pc,
    input  logic [SCHEDULE_WIDTH-1:0]          sched_ready,
    output logic                               busy
);

    logic [NUM_WARPS-1:0]      active_q, active_d;
    logic [NUM_WARPS-1:0]      stalled_q, stalled_d;
    logic [XLEN-1:0]           pc_q    [NUM_WARPS];
    logic [XLEN-1:0]           pc_d    [NUM_WARPS];
    logic [NUM_THREADS-1:0]    tmask_q [NUM_WARPS];
    logic [NUM_THREADS-1:0]    tmask_d [NUM_WARPS];
    logic [NW_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;
    logic [UUID_WIDTH-1:0]     uuid_ctr_q, uuid_ctr_d;
    logic                      busy_q, busy_d;

    logic [SCHEDULE_WIDTH-1:0] lane_valid_q, lane_valid_d;
    logic [UUID_WIDTH-1:0]     lane_uuid_q  [SCHEDULE_WIDTH];
    logic [UUID_WIDTH-1:0]     lane_uuid_d  [SCHEDULE_WIDTH];
    logic [NW_WIDTH-1:0]       lane_wid_q   [SCHEDULE_WIDTH];
    logic [NW_WIDTH-1:0]       lane_wid_d   [SCHEDULE_WIDTH];
    logic [NUM_THREADS-1:0]    lane_tmask_q [SCHEDULE_WIDTH];
    logic [NUM_THREADS-1:0]    lane_tmask_d [SCHEDULE_WIDTH];
    logic [XLEN-1:0]           lane_pc_q    [SCHEDULE_WIDTH];
    logic [XLEN-1:0]           lane_pc_d    [SCHEDULE_WIDTH];

    logic [NUM_WARPS-1:0]      eligible;
    logic [SCHEDULE_WIDTH-1:0] lane_free;

    // A warp being spawned or retired this cycle must not be issued from its stale state.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            eligible[w] = active_q[w] & ~stalled_q[w]
                        & ~(done_valid  && done_wid  == NW_WIDTH'(w))
                        & ~(spawn_valid && spawn_wid == NW_WIDTH'(w));
        end
        for (int k = 0; k < SCHEDULE_WIDTH; k++) begin
            lane_free[k] = ~lane_valid_q[k] | sched_ready[k];
        end
    end

    always_comb begin
        logic [NW_WIDTH:0]   sum;
        logic [NW_WIDTH-1:0] w;
        int                  next_lane;
        int                  n_assign;
        logic                taken;

        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        active_d     = active_q;
        stalled_d    = stalled_q;
        pc_d         = pc_q;
        tmask_d      = tmask_q;
        rr_ptr_d     = rr_ptr_q;
        lane_uuid_d  = lane_uuid_q;
        lane_wid_d   = lane_wid_q;
        lane_tmask_d = lane_tmask_q;
        lane_pc_d    = lane_pc_q;
        lane_valid_d = lane_valid_q & ~lane_free;
        next_lane    = 0;
        n_assign     = 0;
        sum          = '0;
        w            = '0;
        taken        = 1'b0;

        for (int i = 0; i < NUM_WARPS; i++) begin
            sum = {1'b0, rr_ptr_q} + (NW_WIDTH+1)'(i);
            if (sum >= (NW_WIDTH+1)'(NUM_WARPS)) sum = sum - (NW_WIDTH+1)'(NUM_WARPS);
            w     = sum[NW_WIDTH-1:0];
            taken = 1'b0;
            if (eligible[w]) begin
                for (int k = 0; k < SCHEDULE_WIDTH; k++) begin
                    if (!taken && k >= next_lane && lane_free[k]) begin
                        lane_valid_d[k] = 1'b1;
                        lane_uuid_d[k]  = uuid_ctr_q + UUID_WIDTH'(n_assign);
                        lane_wid_d[k]   = w;
                        lane_tmask_d[k] = tmask_q[w];
                        lane_pc_d[k]    = pc_q[w];
                        pc_d[w]         = pc_q[w] + XLEN'(4);
                        stalled_d[w]    = 1'b1;
                        sum             = {1'b0, w} + (NW_WIDTH+1)'(1);
                        if (sum >= (NW_WIDTH+1)'(NUM_WARPS)) sum = '0;
                        rr_ptr_d        = sum[NW_WIDTH-1:0];
                        next_lane       = k + 1;
                        n_assign        = n_assign + 1;
                        taken           = 1'b1;
                    end
                end
            end
        end
        uuid_ctr_d = uuid_ctr_q + UUID_WIDTH'(n_assign);

        // Applied last so that spawn overrides done, which overrides unlock.
        if (unlock_valid && active_q[unlock_wid]) stalled_d[unlock_wid] = 1'b0;
        if (done_valid) begin
            active_d[done_wid]  = 1'b0;
            stalled_d[done_wid] = 1'b0;
        end
        if (spawn_valid) begin
            active_d[spawn_wid]  = |spawn_tmask;
            stalled_d[spawn_wid] = 1'b0;
            pc_d[spawn_wid]      = spawn_pc;
            tmask_d[spawn_wid]   = spawn_tmask;
        end
        busy_d = |active_d;
    end

    // NOTE: state flops use non-blocking assignments; the per-warp and per-lane arrays are
    // small register files that must come out of reset with known contents, so they are reset too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q     <= '0;
            stalled_q    <= '0;
            rr_ptr_q     <= '0;
            uuid_ctr_q   <= '0;
            busy_q       <= 1'b0;
            lane_valid_q <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w]    <= '0;
                tmask_q[w] <= '0;
            end
            for (int k = 0; k < SCHEDULE_WIDTH; k++) begin
                lane_uuid_q[k]  <= '0;
                lane_wid_q[k]   <= '0;
                lane_tmask_q[k] <= '0;
                lane_pc_q[k]    <= '0;
            end
        end else begin
            active_q     <= active_d;
            stalled_q    <= stalled_d;
            rr_ptr_q     <= rr_ptr_d;
            uuid_ctr_q   <= uuid_ctr_d;
            busy_q       <= busy_d;
            lane_valid_q <= lane_valid_d;
            pc_q         <= pc_d;
            tmask_q      <= tmask_d;
            lane_uuid_q  <= lane_uuid_d;
            lane_wid_q   <= lane_wid_d;
            lane_tmask_q <= lane_tmask_d;
            lane_pc_q    <= lane_pc_d;
        end
    end

    always_comb begin
        sched_valid = lane_valid_q;
        busy        = busy_q;
        for (int k = 0; k < SCHEDULE_WIDTH; k++) begin
            sched_uuid[k*UUID_WIDTH +: UUID_WIDTH]    = lane_uuid_q[k];
            sched_wid[k*NW_WIDTH +: NW_WIDTH]         = lane_wid_q[k];
            sched_tmask[k*NUM_THREADS +: NUM_THREADS] = lane_tmask_q[k];
            sched_pc[k*XLEN +: XLEN]                  = lane_pc_q[k];
        end
    end

endmodule

// File: tb/tb_vx_warp_sched.sv
// Directed bench for vx_warp_sched: a vector table drives a single-lane instance, and
// hand-written sequences cover the two-lane round-robin case and reset during a handshake.
module tb_vx_warp_sched;

    logic clk;
    logic reset;

    logic        a_spawn_valid, a_unlock_valid, a_done_valid;
    logic [1:0]  a_spawn_wid, a_unlock_wid, a_done_wid;
    logic [3:0]  a_spawn_tmask;
    logic [31:0] a_spawn_pc;
    logic [0:0]  a_ready, a_valid;
    logic [43:0] a_uuid;
    logic [1:0]  a_wid;
    logic [3:0]  a_tmask;
    logic [31:0] a_pc;
    logic        a_busy;

    logic        b_spawn_valid, b_unlock_valid;
    logic [1:0]  b_spawn_wid, b_unlock_wid;
    logic [3:0]  b_spawn_tmask;
    logic [31:0] b_spawn_pc;
    logic [1:0]  b_ready, b_valid;
    logic [87:0] b_uuid;
    logic [3:0]  b_wid;
    logic [7:0]  b_tmask;
    logic [63:0] b_pc;
    logic        b_busy;

    int total = 0;
    int bad   = 0;

    vx_warp_sched #(.SCHEDULE_WIDTH(1)) u_one (
        .clk(clk), .reset(reset),
        .spawn_valid(a_spawn_valid), .spawn_wid(a_spawn_wid), .spawn_tmask(a_spawn_tmask), .spawn_pc(a_spawn_pc),
        .unlock_valid(a_unlock_valid), .unlock_wid(a_unlock_wid),
        .done_valid(a_done_valid), .done_wid(a_done_wid),
        .sched_valid(a_valid), .sched_uuid(a_uuid), .sched_wid(a_wid), .sched_tmask(a_tmask), .sched_pc(a_pc),
        .sched_ready(a_ready), .busy(a_busy)
    );

    vx_warp_sched #(.SCHEDULE_WIDTH(2)) u_two (
        .clk(clk), .reset(reset),
        .spawn_valid(b_spawn_valid), .spawn_wid(b_spawn_wid), .spawn_tmask(b_spawn_tmask), .spawn_pc(b_spawn_pc),
        .unlock_valid(b_unlock_valid), .unlock_wid(b_unlock_wid),
        .done_valid(1'b0), .done_wid(2'd0),
        .sched_valid(b_valid), .sched_uuid(b_uuid), .sched_wid(b_wid), .sched_tmask(b_tmask), .sched_pc(b_pc),
        .sched_ready(b_ready), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit          rst;
        bit          sv;  logic [1:0] sw; logic [3:0] stm; logic [31:0] spc;
        bit          uv;  logic [1:0] uw;
        bit          dv;  logic [1:0] dw;
        bit          rdy;
        bit          ev;  logic [1:0] ew; logic [3:0] etm; logic [31:0] epc; logic [43:0] eu;
        bit          cb;  bit eb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {a_spawn_valid, a_unlock_valid, a_done_valid} = '0;
        {a_spawn_wid, a_unlock_wid, a_done_wid} = '0;
        a_spawn_tmask = '0; a_spawn_pc = '0; a_ready = 1'b0;
        {b_spawn_valid, b_unlock_valid} = '0;
        {b_spawn_wid, b_unlock_wid} = '0;
        b_spawn_tmask = '0; b_spawn_pc = '0; b_ready = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic v(input bit rs, input bit sv, input int sw, input logic [3:0] stm, input logic [31:0] spc,
                     input bit uv, input int uw, input bit dv, input int dw, input bit rdy,
                     input bit ev, input int ew, input logic [3:0] etm, input logic [31:0] epc, input int eu,
                     input bit cb, input bit eb);
        vec_t t;
        t.rst = rs; t.sv = sv; t.sw = 2'(sw); t.stm = stm; t.spc = spc;
        t.uv = uv; t.uw = 2'(uw); t.dv = dv; t.dw = 2'(dw); t.rdy = rdy;
        t.ev = ev; t.ew = 2'(ew); t.etm = etm; t.epc = epc; t.eu = 44'(eu);
        t.cb = cb; t.eb = eb;
        vecs.push_back(t);
    endtask

    task automatic b_drive(input bit sv, input int sw, input logic [3:0] stm, input logic [31:0] spc,
                           input bit uv, input int uw, input logic [1:0] rdy);
        b_spawn_valid = sv; b_spawn_wid = 2'(sw); b_spawn_tmask = stm; b_spawn_pc = spc;
        b_unlock_valid = uv; b_unlock_wid = 2'(uw); b_ready = rdy;
    endtask

    task automatic chk2(input string tag, input int k, input bit ev, input int ew,
                        input logic [3:0] etm, input logic [31:0] epc, input int eu);
        check({tag, " valid"}, 64'(b_valid[k]), 64'(ev));
        if (ev) begin
            check({tag, " wid"},   64'(b_wid[k*2 +: 2]),    64'(ew));
            check({tag, " tmask"}, 64'(b_tmask[k*4 +: 4]),  64'(etm));
            check({tag, " pc"},    64'(b_pc[k*32 +: 32]),   64'(epc));
            check({tag, " uuid"},  64'(b_uuid[k*44 +: 44]), 64'(eu));
        end
    endtask

    initial begin
        // rst sv sw stm spc | uv uw | dv dw | rdy | ev ew etm epc uuid | cb eb
        // first issue two cycles after spawn, then single-warp reissue after unlock
        v(1, 1,2,4'b1011,32'h8000_0000, 0,0, 0,0, 1, 0,0,4'b0000,32'h0,0,           0,0);
        v(0, 0,0,4'b0000,32'h0,         0,0, 0,0, 1, 1,2,4'b1011,32'h8000_0000,0,   1,1);
        v(0, 0,0,4'b0000,32'h0,         1,2, 0,0, 1, 0,0,4'b0000,32'h0,0,           0,0);
        v(0, 0,0,4'b0000,32'h0,         0,0, 0,0, 1, 1,2,4'b1011,32'h8000_0004,1,   0,0);
        // four warps in round robin, then a 5-cycle stall, then done while a warp sits in the lane
        v(1, 1,0,4'b0001,32'h100,       0,0, 0,0, 1, 0,0,4'b0000,32'h0,0,           0,0);
        v(0, 1,1,4'b0011,32'h200,       0,0, 0,0, 1, 1,0,4'b0001,32'h100,0,         0,0);
        v(0, 1,2,4'b0111,32'h300,       0,0, 0,0, 1, 1,1,4'b0011,32'h200,1,         0,0);
        v(0, 1,3,4'b1111,32'h400,       1,0, 0,0, 1, 1,2,4'b0111,32'h300,2,         0,0);
        v(0, 0,0,4'b0000,32'h0,         1,1, 0,0, 1, 1,3,4'b1111,32'h400,3,         0,0);
        v(0, 0,0,4'b0000,32'h0,         1,2, 0,0, 1, 1,0,4'b0001,32'h104,4,         0,0);
        v(0, 0,0,4'b0000,32'h0,         1,3, 0,0, 0, 1,0,4'b0001,32'h104,4,         0,0);
        for (int i = 0; i < 4; i++)
            v(0, 0,0,4'b0000,32'h0,     0,0, 0,0, 0, 1,0,4'b0001,32'h104,4,         0,0);
        v(0, 0,0,4'b0000,32'h0,         0,0, 0,0, 1, 1,1,4'b0011,32'h204,5,         0,0);
        v(0, 0,0,4'b0000,32'h0,         0,0, 1,1, 0, 1,1,4'b0011,32'h204,5,         1,1);
        v(0, 0,0,4'b0000,32'h0,         1,1, 0,0, 0, 1,1,4'b0011,32'h204,5,         0,0);
        v(0, 0,0,4'b0000,32'h0,         1,1, 0,0, 1, 1,2,4'b0111,32'h304,6,         1,1);
        v(0, 0,0,4'b0000,32'h0,         1,1, 1,0, 1, 1,3,4'b1111,32'h404,7,         0,0);
        v(0, 0,0,4'b0000,32'h0,         0,0, 1,2, 1, 0,0,4'b0000,32'h0,0,           0,0);
        v(0, 0,0,4'b0000,32'h0,         1,1, 1,3, 1, 0,0,4'b0000,32'h0,0,           0,0);
        v(0, 0,0,4'b0000,32'h0,         0,0, 0,0, 1, 0,0,4'b0000,32'h0,0,           0,0);
        v(0, 0,0,4'b0000,32'h0,         0,0, 0,0, 1, 0,0,4'b0000,32'h0,0,           1,0);
        // spawn+done same wid, unlock of inactive warp, zero-mask spawn, spawn overwrite
        v(1, 1,1,4'b1111,32'h1000,      0,0, 1,1, 1, 0,0,4'b0000,32'h0,0,           0,0);
        v(0, 0,0,4'b0000,32'h0,         1,3, 0,0, 1, 1,1,4'b1111,32'h1000,0,        1,1);
        v(0, 0,0,4'b0000,32'h0,         0,0, 0,0, 1, 0,0,4'b0000,32'h0,0,           0,0);
        v(0, 1,2,4'b0000,32'h2000,      0,0, 0,0, 1, 0,0,4'b0000,32'h0,0,           0,0);
        v(0, 0,0,4'b0000,32'h0,         0,0, 0,0, 1, 0,0,4'b0000,32'h0,0,           0,0);
        v(0, 1,1,4'b1100,32'h3000,      0,0, 0,0, 1, 0,0,4'b0000,32'h0,0,           0,0);
        v(0, 0,0,4'b0000,32'h0,         0,0, 0,0, 1, 1,1,4'b1100,32'h3000,1,        0,0);

        do_reset();
        check("reset valid", 64'(a_valid), 64'd0);
        check("reset busy",  64'(a_busy),  64'd0);
        check("reset uuid",  64'(a_uuid),  64'd0);
        check("reset pc",    64'(a_pc),    64'd0);
        check("reset two valid", 64'(b_valid), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t t;
            t = vecs[i];
            if (t.rst) do_reset();
            a_spawn_valid = t.sv; a_spawn_wid = t.sw; a_spawn_tmask = t.stm; a_spawn_pc = t.spc;
            a_unlock_valid = t.uv; a_unlock_wid = t.uw;
            a_done_valid = t.dv; a_done_wid = t.dw;
            a_ready = t.rdy;
            step();
            check($sformatf("row%0d valid", i), 64'(a_valid), 64'(t.ev));
            if (t.ev) begin
                check($sformatf("row%0d wid", i),   64'(a_wid),   64'(t.ew));
                check($sformatf("row%0d tmask", i), 64'(a_tmask), 64'(t.etm));
                check($sformatf("row%0d pc", i),    64'(a_pc),    64'(t.epc));
                check($sformatf("row%0d uuid", i),  64'(a_uuid),  64'(t.eu));
            end
            if (t.cb) check($sformatf("row%0d busy", i), 64'(a_busy), 64'(t.eb));
        end

        // Two lanes: build rr_ptr=3 with all four warps then eligible at once.
        do_reset();
        b_drive(1, 0, 4'b0001, 32'h10, 0, 0, 2'b11); step();
        chk2("w2 c0 l0", 0, 0, 0, 4'b0000, 32'h0, 0);
        b_drive(1, 1, 4'b0010, 32'h20, 0, 0, 2'b11); step();
        chk2("w2 c1 l0", 0, 1, 0, 4'b0001, 32'h10, 0);
        chk2("w2 c1 l1", 1, 0, 0, 4'b0000, 32'h0, 0);
        b_drive(1, 2, 4'b0100, 32'h30, 0, 0, 2'b00); step();
        chk2("w2 c2 l0", 0, 1, 0, 4'b0001, 32'h10, 0);
        chk2("w2 c2 l1", 1, 1, 1, 4'b0010, 32'h20, 1);
        b_drive(1, 3, 4'b1000, 32'h40, 0, 0, 2'b01); step();
        chk2("w2 c3 l0", 0, 1, 2, 4'b0100, 32'h30, 2);
        chk2("w2 c3 l1", 1, 1, 1, 4'b0010, 32'h20, 1);
        for (int w = 0; w < 3; w++) begin
            b_drive(0, 0, 4'b0000, 32'h0, 1, w, 2'b00); step();
        end
        chk2("w2 hold l0", 0, 1, 2, 4'b0100, 32'h30, 2);
        chk2("w2 hold l1", 1, 1, 1, 4'b0010, 32'h20, 1);
        b_drive(0, 0, 4'b0000, 32'h0, 0, 0, 2'b11); step();
        chk2("w2 rr3 l0", 0, 1, 3, 4'b1000, 32'h40, 3);
        chk2("w2 rr3 l1", 1, 1, 0, 4'b0001, 32'h14, 4);
        step();
        chk2("w2 rr1 l0", 0, 1, 1, 4'b0010, 32'h24, 5);
        chk2("w2 rr1 l1", 1, 1, 2, 4'b0100, 32'h34, 6);

        // Asynchronous reset while a lane holds an unaccepted warp.
        do_reset();
        a_spawn_valid = 1'b1; a_spawn_wid = 2'd0; a_spawn_tmask = 4'b0001; a_spawn_pc = 32'h50;
        a_ready = 1'b0;
        step();
        a_spawn_valid = 1'b0;
        step();
        check("pre-reset valid", 64'(a_valid), 64'd1);
        check("pre-reset pc",    64'(a_pc),    64'h50);
        #2 reset = 1'b1;
        #1;
        check("async reset valid", 64'(a_valid), 64'd0);
        check("async reset pc",    64'(a_pc),    64'd0);
        check("async reset busy",  64'(a_busy),  64'd0);
        step();
        reset = 1'b0;
        a_ready = 1'b1;
        step();
        step();
        check("post-reset valid", 64'(a_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
